// File: rtl/triangle_seq_checker_if.sv
// triangle_seq_checker_if
//   Bundles the sample stream into the checker and the checker's status
//   outputs.
//   master : the side that produces samples (counter, bus tap or bench).
//   slave  : the checker itself.
//   Signals:
//     sample_en    - cont_in holds a new sample this cycle
//     cont_in      - counter value under check (WIDTH bits)
//     dir          - tracked direction, 0 = up, 1 = down
//     locked       - sequence confirmed for LOCK_N consecutive matches
//     peak_pulse   - one-cycle pulse, MAX accepted while tracking up
//     trough_pulse - one-cycle pulse, 0 accepted while tracking down
//     err          - one-cycle pulse, sample broke the sequence
//     err_count    - saturating mismatch count
//     period_count - wrapping count of completed periods
//     state_dbg    - current FSM state (ACQ=0, SYNC=1, UP=2, DOWN=3)
//
// Handshake: sample_en is a valid strobe with no back-pressure. The checker
// always accepts, so a sample is consumed on every rising clock edge where
// sample_en=1. cont_in is ignored when sample_en=0.
interface triangle_seq_checker_if #(
  parameter int WIDTH = 4
);
  logic             sample_en;
  logic [WIDTH-1:0] cont_in;
  logic             dir;
  logic             locked;
  logic             peak_pulse;
  logic             trough_pulse;
  logic             err;
  logic [7:0]       err_count;
  logic [7:0]       period_count;
  logic [1:0]       state_dbg;

  modport master (
    output sample_en, cont_in,
    input  dir, locked, peak_pulse, trough_pulse, err,
           err_count, period_count, state_dbg
  );

  modport slave (
    input  sample_en, cont_in,
    output dir, locked, peak_pulse, trough_pulse, err,
           err_count, period_count, state_dbg
  );
endinterface

// File: rtl/triangle_seq_checker.sv
// triangle_seq_checker
//   Receive-side monitor for an up/down triangle counter (0..MAX..0..).
//   It tracks direction and phase, reports lock, peaks, troughs and completed
//   periods, and flags every sample that breaks the sequence.
//   Ports:
//     clock - single clock, all logic on posedge
//     reset - synchronous, active-high, dominates every other input
//     bus   - triangle_seq_checker_if.slave (samples in, status out)
//   All outputs are registered, so the response to a sample appears one
//   cycle after the edge that consumed it.
module triangle_seq_checker #(
  parameter int WIDTH  = 4,
  parameter int LOCK_N = 4
) (
  input logic                   clock,
  input logic                   reset,
  triangle_seq_checker_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX    = '1;
  localparam logic [WIDTH-1:0] ZERO   = '0;
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [3:0]       LOCK_V = 4'(LOCK_N);

  typedef enum logic [1:0] {
    ACQ  = 2'd0,
    SYNC = 2'd1,
    UP   = 2'd2,
    DOWN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [3:0]       good_q, good_d;
  logic             dir_q, dir_d;
  logic             locked_q, locked_d;
  logic             peak_q, peak_d;
  logic             trough_q, trough_d;
  logic             err_q, err_d;
  logic [7:0]       err_count_q, err_count_d;
  logic [7:0]       period_count_q, period_count_d;

  // Expected next sample in UP/DOWN. At the endpoints the expectation folds
  // back instead of wrapping, and the turn flag tells the FSM to reverse.
  logic [WIDTH-1:0] exp_val;
  logic             turn;
  logic [3:0]       good_inc;

  always_comb begin
    exp_val = ZERO;
    turn    = 1'b0;
    if (state_q == DOWN) begin
      if (prev_q == ZERO) begin
        exp_val = ONE;
        turn    = 1'b1;
      end else begin
        exp_val = prev_q - ONE;
      end
    end else begin
      if (prev_q == MAX) begin
        exp_val = MAX - ONE;
        turn    = 1'b1;
      end else begin
        exp_val = prev_q + ONE;
      end
    end
  end

  assign good_inc = (good_q >= LOCK_V) ? LOCK_V : good_q + 4'd1;

  always_comb begin
    state_d        = state_q;
    prev_d         = prev_q;
    good_d         = good_q;
    dir_d          = dir_q;
    peak_d         = 1'b0;
    trough_d       = 1'b0;
    err_d          = 1'b0;
    err_count_d    = err_count_q;
    period_count_d = period_count_q;

    if (bus.sample_en) begin
      prev_d = bus.cont_in;
      unique case (state_q)
        ACQ: begin
          state_d = SYNC;
        end
        SYNC: begin
          if (prev_q != MAX && bus.cont_in == prev_q + ONE) begin
            state_d = UP;
            dir_d   = 1'b0;
            good_d  = 4'd1;
          end else if (prev_q != ZERO && bus.cont_in == prev_q - ONE) begin
            state_d = DOWN;
            dir_d   = 1'b1;
            good_d  = 4'd1;
          end else begin
            err_d = 1'b1;
          end
        end
        UP, DOWN: begin
          if (bus.cont_in == exp_val) begin
            good_d = good_inc;
            if (turn) begin
              state_d = (state_q == UP) ? DOWN : UP;
              dir_d   = (state_q == UP);
            end
            // A turn sample is MAX-1 or 1, so it can never be a peak/trough.
            if (state_q == UP && bus.cont_in == MAX) begin
              peak_d = 1'b1;
            end
            if (state_q == DOWN && bus.cont_in == ZERO) begin
              trough_d       = 1'b1;
              period_count_d = period_count_q + 8'd1;
            end
          end else begin
            err_d   = 1'b1;
            good_d  = 4'd0;
            state_d = SYNC;
          end
        end
        default: state_d = ACQ;
      endcase

      if (err_d && err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end

    locked_d = ((state_d == UP) || (state_d == DOWN)) && (good_d == LOCK_V);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ACQ;
      prev_q         <= ZERO;
      good_q         <= 4'd0;
      dir_q          <= 1'b0;
      locked_q       <= 1'b0;
      peak_q         <= 1'b0;
      trough_q       <= 1'b0;
      err_q          <= 1'b0;
      err_count_q    <= 8'd0;
      period_count_q <= 8'd0;
    end else begin
      state_q        <= state_d;
      prev_q         <= prev_d;
      good_q         <= good_d;
      dir_q          <= dir_d;
      locked_q       <= locked_d;
      peak_q         <= peak_d;
      trough_q       <= trough_d;
      err_q          <= err_d;
      err_count_q    <= err_count_d;
      period_count_q <= period_count_d;
    end
  end

  assign bus.dir          = dir_q;
  assign bus.locked       = locked_q;
  assign bus.peak_pulse   = peak_q;
  assign bus.trough_pulse = trough_q;
  assign bus.err          = err_q;
  assign bus.err_count    = err_count_q;
  assign bus.period_count = period_count_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_triangle_seq_checker.sv
module tb_triangle_seq_checker;

  localparam int WIDTH  = 4;
  localparam int LOCK_N = 4;
  localparam int MAXV   = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  triangle_seq_checker_if #(.WIDTH(WIDTH)) bus ();

  triangle_seq_checker #(.WIDTH(WIDTH), .LOCK_N(LOCK_N)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // expected vector: {dir, locked, peak, trough, err, err_count, period_count}
  logic [20:0] exp_q[$];

  // ---------------- reference model ----------------
  int m_state = 0;  // 0 acq, 1 sync, 2 up, 3 down
  int m_prev  = 0;
  int m_good  = 0;
  int m_dir   = 0;
  int m_errc  = 0;
  int m_per   = 0;

  task automatic model_step(input bit r, input bit en, input int v,
                            output logic [20:0] e);
    bit p, t, x, lk;
    int nxt;
    p = 0; t = 0; x = 0;
    if (r) begin
      m_state = 0; m_prev = 0; m_good = 0; m_dir = 0; m_errc = 0; m_per = 0;
    end else if (en) begin
      case (m_state)
        0: m_state = 1;
        1: begin
          if (m_prev != MAXV && v == m_prev + 1) begin
            m_state = 2; m_dir = 0; m_good = 1;
          end else if (m_prev != 0 && v == m_prev - 1) begin
            m_state = 3; m_dir = 1; m_good = 1;
          end else x = 1;
        end
        default: begin
          if (m_state == 2) nxt = (m_prev == MAXV) ? MAXV - 1 : m_prev + 1;
          else              nxt = (m_prev == 0) ? 1 : m_prev - 1;
          if (v == nxt) begin
            if (m_good < LOCK_N) m_good++;
            if (m_state == 2 && v == MAXV) p = 1;
            if (m_state == 3 && v == 0) begin
              t = 1;
              m_per = (m_per + 1) % 256;
            end
            if (m_state == 2 && m_prev == MAXV) begin m_state = 3; m_dir = 1; end
            else if (m_state == 3 && m_prev == 0) begin m_state = 2; m_dir = 0; end
          end else begin
            x = 1; m_good = 0; m_state = 1;
          end
        end
      endcase
      m_prev = v;
      if (x && m_errc < 255) m_errc++;
    end
    lk = (m_state >= 2) && (m_good == LOCK_N);
    e = {m_dir[0], lk, p, t, x, m_errc[7:0], m_per[7:0]};
  endtask

  // ---------------- driver ----------------
  // Returns one time unit after the edge that consumed the sample, so the
  // caller can read the registered response directly.
  task automatic drive(input bit r, input bit en, input int v);
    logic [20:0] e;
    @(negedge clk);
    rst           = r;
    bus.sample_en = en;
    bus.cont_in   = 4'(v);
    model_step(r, en, v, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap();
    int g;
    g = $urandom_range(1, 3);
    for (int k = 0; k < g; k++) drive(0, 0, $urandom_range(0, 15));
  endtask

  // ---------------- scoreboard ----------------
  logic [20:0] sb_exp, sb_act;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      sb_exp = exp_q.pop_front();
      sb_act = {bus.dir, bus.locked, bus.peak_pulse, bus.trough_pulse,
                bus.err, bus.err_count, bus.period_count};
      n_vec++;
      if (sb_act !== sb_exp) begin
        n_err++;
        $display("FAIL scoreboard t=%0t dir/lk/pk/tr/err act=%b exp=%b errc act=%0d exp=%0d per act=%0d exp=%0d",
                 $time, sb_act[20:16], sb_exp[20:16], sb_act[15:8],
                 sb_exp[15:8], sb_act[7:0], sb_exp[7:0]);
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(1, 0, 0);
    drive(1, 0, 0);
    n_vec++;
    if ({bus.dir, bus.locked, bus.peak_pulse, bus.trough_pulse, bus.err,
         bus.err_count, bus.period_count} !== 21'd0) begin
      n_err++;
      $display("FAIL reset_outputs act=%b/%0d/%0d exp=0",
               {bus.dir, bus.locked, bus.peak_pulse, bus.trough_pulse, bus.err},
               bus.err_count, bus.period_count);
    end
  endtask

  // 0..15..0,1 with optional idle gaps between samples
  task automatic run_triangle(input bit gapped);
    int seq[$];
    int peaks, troughs, errs;
    peaks = 0; troughs = 0; errs = 0;
    for (int i = 0; i <= 15; i++) seq.push_back(i);
    for (int i = 14; i >= 0; i--) seq.push_back(i);
    seq.push_back(1);
    drive(1, 0, 0);
    for (int i = 0; i < seq.size(); i++) begin
      drive(0, 1, seq[i]);
      peaks   += int'(bus.peak_pulse);
      troughs += int'(bus.trough_pulse);
      errs    += int'(bus.err);
      if (i == 3 || i == 4) begin
        n_vec++;
        if (bus.locked !== (i == 4)) begin
          n_err++;
          $display("FAIL lock_rise sample=%0d locked=%b exp=%b", i, bus.locked, i == 4);
        end
      end
      if (i == 16) begin
        n_vec++;
        if (bus.dir !== 1'b1) begin
          n_err++;
          $display("FAIL dir_after_14 dir=%b exp=1", bus.dir);
        end
      end
      if (i == 30) begin
        n_vec++;
        if (bus.trough_pulse !== 1'b1 || bus.period_count !== 8'd1) begin
          n_err++;
          $display("FAIL trough_period trough=%b per=%0d exp=1/1",
                   bus.trough_pulse, bus.period_count);
        end
      end
      if (gapped) begin
        idle_gap();
        n_vec++;
        if (bus.peak_pulse !== 1'b0 || bus.trough_pulse !== 1'b0 || bus.err !== 1'b0) begin
          n_err++;
          $display("FAIL idle_pulses pk/tr/err=%b%b%b exp=000",
                   bus.peak_pulse, bus.trough_pulse, bus.err);
        end
      end
    end
    n_vec++;
    if (peaks != 1 || troughs != 1 || errs != 0) begin
      n_err++;
      $display("FAIL pulse_totals peaks=%0d troughs=%0d errs=%0d exp=1/1/0",
               peaks, troughs, errs);
    end
  endtask

  task automatic test_lock_period();
    run_triangle(0);
  endtask

  task automatic test_gapped();
    run_triangle(1);
  endtask

  task automatic test_error_resync();
    int seq[12] = '{0, 1, 2, 3, 4, 5, 7, 8, 9, 10, 11, 12};
    drive(1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, seq[i]);
      if (seq[i] == 7) begin
        n_vec++;
        if (bus.err !== 1'b1 || bus.err_count !== 8'd1 || bus.locked !== 1'b0) begin
          n_err++;
          $display("FAIL err_on_7 err=%b errc=%0d locked=%b exp=1/1/0",
                   bus.err, bus.err_count, bus.locked);
        end
      end
      if (seq[i] == 10 || seq[i] == 11) begin
        n_vec++;
        if (bus.locked !== (seq[i] == 11)) begin
          n_err++;
          $display("FAIL relock val=%0d locked=%b exp=%b", seq[i], bus.locked, seq[i] == 11);
        end
      end
    end
  endtask

  task automatic test_mid_start();
    drive(1, 0, 0);
    for (int v = 9; v >= 0; v--) begin
      drive(0, 1, v);
      if (v == 8) begin
        n_vec++;
        if (bus.dir !== 1'b1) begin
          n_err++;
          $display("FAIL down_after_8 dir=%b exp=1", bus.dir);
        end
      end
      if (v == 0) begin
        n_vec++;
        if (bus.trough_pulse !== 1'b1) begin
          n_err++;
          $display("FAIL trough_after_0 trough=%b exp=1", bus.trough_pulse);
        end
      end
    end
    drive(0, 1, 1);
    n_vec++;
    if (bus.dir !== 1'b0) begin
      n_err++;
      $display("FAIL up_after_1 dir=%b exp=0", bus.dir);
    end
    drive(0, 1, 2);
    // repeated MAX is not a plateau
    drive(1, 0, 0);
    drive(0, 1, 15);
    drive(0, 1, 15);
    n_vec++;
    if (bus.err !== 1'b1) begin
      n_err++;
      $display("FAIL repeat_15 err=%b exp=1", bus.err);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0);
    for (int i = 0; i <= 15; i++) drive(0, 1, i);
    for (int i = 14; i >= 10; i--) drive(0, 1, i);
    drive(1, 1, 9);
    n_vec++;
    if ({bus.dir, bus.locked, bus.peak_pulse, bus.trough_pulse, bus.err,
         bus.err_count, bus.period_count} !== 21'd0) begin
      n_err++;
      $display("FAIL reset_mid outputs not cleared dir=%b locked=%b errc=%0d",
               bus.dir, bus.locked, bus.err_count);
    end
    drive(0, 1, 8);
    n_vec++;
    if (bus.err !== 1'b0) begin
      n_err++;
      $display("FAIL acq_after_reset err=%b exp=0", bus.err);
    end
    drive(0, 1, 7);
    drive(0, 1, 6);
  endtask

  task automatic test_saturation_wrap();
    drive(1, 0, 0);
    for (int i = 0; i < 301; i++) drive(0, 1, 15);
    n_vec++;
    if (bus.err_count !== 8'd255) begin
      n_err++;
      $display("FAIL err_sat errc=%0d exp=255", bus.err_count);
    end
    drive(1, 0, 0);
    drive(0, 1, 0);
    for (int p = 0; p < 256; p++) begin
      for (int i = 1; i <= 15; i++) drive(0, 1, i);
      for (int i = 14; i >= 0; i--) drive(0, 1, i);
    end
    n_vec++;
    if (bus.period_count !== 8'd0 || bus.trough_pulse !== 1'b1) begin
      n_err++;
      $display("FAIL period_wrap per=%0d trough=%b exp=0/1", bus.period_count, bus.trough_pulse);
    end
    for (int i = 1; i <= 15; i++) drive(0, 1, i);
    for (int i = 14; i >= 0; i--) drive(0, 1, i);
    n_vec++;
    if (bus.period_count !== 8'd1) begin
      n_err++;
      $display("FAIL period_after_wrap per=%0d exp=1", bus.period_count);
    end
  endtask

  initial begin
    bus.sample_en = 1'b0;
    bus.cont_in   = '0;
    test_reset();
    test_lock_period();
    test_error_resync();
    test_gapped();
    test_mid_start();
    test_reset_mid();
    test_saturation_wrap();
    drive(0, 0, 0);
    @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/triangle_seq_checker.md
# triangle_seq_checker

Receive-side monitor for the 4-bit up/down "triangle" counter stream (0→15→0→…, one step per sample). Consumes the counter value, tracks its direction and phase, reports lock, peaks, troughs and completed periods, and flags any sample that breaks the sequence. It sits downstream of the counter, or on any bus that carries its value, as a built-in self-check and as a phase reference for other logic.

## Interface
- WIDTH, 4, counter width; WIDTH ≥ 2; MAX = 2^WIDTH − 1
- LOCK_N, 4, consecutive matching samples required before `locked` asserts; 1..15
- clock  input  1  single clock; all logic on posedge
- reset  input  1  synchronous, active-high; dominates every other input
- sample_en  input  1  `cont_in` holds a new sample this cycle
- cont_in  input  WIDTH  counter value under check
- dir  output  1  tracked direction; 0 = up, 1 = down
- locked  output  1  sequence confirmed for ≥ LOCK_N consecutive matches
- peak_pulse  output  1  one-cycle pulse: MAX accepted while tracking up
- trough_pulse  output  1  one-cycle pulse: 0 accepted while tracking down
- err  output  1  one-cycle pulse: sample mismatched the expected value
- err_count  output  8  mismatch count; saturates at 255
- period_count  output  8  completed periods (troughs); wraps 255→0

## Operation
- Registers: state, prev (WIDTH), good (4-bit, saturates at LOCK_N), dir, err_count, period_count, and the three pulse flops.
- All actions below occur only on cycles with `sample_en`=1. With `sample_en`=0, all registers hold and all pulses are 0.
- States:
  - ACQ: capture `prev`←`cont_in`; go to SYNC; no pulses.
  - SYNC: `cont_in`==`prev`+1 (and `prev`≠MAX) → UP, `dir`=0, `good`=1. `cont_in`==`prev`−1 (and `prev`≠0) → DOWN, `dir`=1, `good`=1. Otherwise `err` pulse, `err_count`+1, stay in SYNC. `prev`←`cont_in` in every case.
  - UP: expected = `prev`+1 if `prev`<MAX, else MAX−1 with a move to DOWN (`dir`←1). On a match with `cont_in`==MAX: `peak_pulse`.
  - DOWN: expected = `prev`−1 if `prev`>0, else 1 with a move to UP (`dir`←0). On a match with `cont_in`==0: `trough_pulse` and `period_count`+1.
- On a match in UP or DOWN: `good`←min(`good`+1, LOCK_N); `prev`←`cont_in`.
- On a mismatch in UP or DOWN: `err` pulse, `err_count`+1 (saturating), `good`←0, `prev`←`cont_in`, state→SYNC, `dir` holds.
- `locked` = (state is UP or DOWN) and `good`==LOCK_N.
- A repeated value (e.g. 15,15 or 0,0) is a mismatch. There is no hold or plateau in the protocol.
- Arithmetic: expected-value computation is WIDTH bits with explicit endpoint checks, so MAX+1 never wraps to 0 and 0−1 never wraps to MAX.

## Timing
- Reset: state=ACQ. `dir`, `locked`, `peak_pulse`, `trough_pulse`, `err`, `err_count`, `period_count`, `good` and `prev` all clear to 0 on the clock edge where `reset`=1.
- Reset mid-operation takes effect on the next edge regardless of `sample_en`. The first sample after reset goes to ACQ.
- All outputs are registered. The response to a sample is visible on the cycle after that sample's `sample_en` edge (latency 1).
- Pulses are high for exactly one cycle, even if the next cycle is idle.
- `err` and `peak_pulse`/`trough_pulse` are mutually exclusive for any one sample.
- `err_count` saturation and `period_count` wrap both happen in the same cycle as the triggering pulse.

## Test plan
- Lock and period: reset, then drive the counter sequence 0,1,…,15,14,…,0,1 with `sample_en`=1 every cycle → `locked` rises the cycle after sample 4; `peak_pulse` fires once, after 15; `dir` becomes 1 after 14; `trough_pulse` fires and `period_count`=1 after the second 0; `err`=0 throughout.
- Error and resync: in a locked up-stream, drive …,4,5,7,8,9,… → `err` pulses once after 7, `err_count`=1, `locked`=0. After 8 the checker is in UP with `good`=1, and `locked` re-asserts after LOCK_N−1 further matches (after 11).
- Gapped samples: same stream as the first test, with `sample_en` low for 1–3 random cycles between samples → identical pulse and count sequence; no pulses and no state change on idle cycles.
- Mid-sequence start and endpoints: after reset, drive 9,8,7,…,0,1,2 → DOWN entered after 8, `dir`=1, `trough_pulse` after 0, `dir`=0 after 1. A separate case drives 15,15 → `err`.
- Reset mid-operation: assert `reset` for one cycle while locked in DOWN with `sample_en`=1 → all outputs 0 on the next cycle; the following sample is treated as ACQ and produces no `err`.
- Saturation and wrap: drive 300 mismatches → `err_count` holds at 255. Drive 256 complete periods → `period_count` returns to 0 and then continues counting.
